scan_display_driver: RTL and testbench
======================================

SCAN_DISPLAY_DRIVER -- requirements
Module: scan_display_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, giving clocks per digit slot (1 kHz digit rate at 100 MHz).
REQ-002 SHALL have parameter BLINK_DIV, default 33333333, giving clocks per blink half-period (about 1.5 Hz).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port minutes, input, 6 bits: binary minutes value, 0-59.
REQ-006 SHALL have port seconds, input, 6 bits: binary seconds value, 0-59.
REQ-007 SHALL have port adjust, input, 1 bit: 1 enables blinking of the selected field.
REQ-008 SHALL have port select, input, 1 bit: 0 selects minutes, 1 selects seconds.
REQ-009 SHALL have port seg, output, 7 bits: cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 SHALL have port an, output, 4 bits: anodes, active-low, one-hot-low, registered.

Function
REQ-011 SHALL map the digits as follows: an[3] = minutes tens, an[2] = minutes ones, an[1] = seconds tens, an[0] = seconds ones.
REQ-012 SHALL use a scan counter that counts 0 to SCAN_DIV-1 and wraps; the digit index (2 bits) advances once per wrap, in the order 0,1,2,3,0.
REQ-013 SHALL register the an and seg outputs for the new index on the clock edge at which the scan counter wraps; the latency from wrap to the output change is exactly 1 clock.
REQ-014 SHALL capture minutes and seconds into a snapshot register only when the index advances from 3 to 0, so a frame never mixes two input values.
REQ-015 SHALL clamp snapshot values of 60-63 to 59 before BCD split.
REQ-016 SHALL split each value into BCD digits using tens = value/10 and ones = value%10, both 4 bits.
REQ-017 SHALL encode digits 0-9 as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 SHALL run the blink counter (0 to BLINK_DIV-1) only while adjust=1, toggling blink_on at each wrap.
REQ-019 SHALL, while adjust=0, hold the blink counter at 0 and force blink_on=1 (visible).
REQ-020 SHALL drive both digits of the selected field with seg=1111111 while adjust=1 and blink_on=0; an SHALL still scan normally.
REQ-021 SHALL, when adjust rises, begin blinking from the visible phase, with the first blank occurring BLINK_DIV clocks later.
REQ-022 SHALL take effect on select changes at the next digit-slot update, without resetting the blink phase.
REQ-023 SHALL keep exactly one an bit low at all times outside reset.

Reset
REQ-024 SHALL, while reset=1, set an=1111 and seg=1111111 (all dark) on the next edge.
REQ-025 SHALL, while reset=1, clear the scan counter, the blink counter, the digit index and the snapshot, and set blink_on=1.
REQ-026 SHALL, on the first clock edge after reset deasserts, capture the snapshot and register digit index 0 (an=1110).
REQ-027 SHALL, on reset asserted mid-frame or mid-blink, abandon the current frame or blink with no partial state retained.

Structure
REQ-028 SHALL place the segment encoding constants, the blank code 1111111 and the default SCAN_DIV/BLINK_DIV values in a shared package.
REQ-029 SHALL place the digit-to-segment lookup in the sub-module seg7_decoder (4-bit in, 7-bit out, combinational; codes 10-15 SHALL decode to blank).

Verification (SCAN_DIV=4, BLINK_DIV=8)
REQ-030 SHALL cover: reset held 3 clocks -> an=1111, seg=1111111; release with minutes=12, seconds=34 -> an=1110 with seg=0011001, then an=1101 with 0110000, then an=1011 with 0100100, then an=0111 with 1111001, each slot lasting 4 clocks.
REQ-031 SHALL cover: seconds changed from 34 to 35 mid-frame -> seg for an[0] changes only after the next 3-to-0 wrap.
REQ-032 SHALL cover: minutes=63 -> an[3] shows 5 (0010010) and an[2] shows 9 (0010000).
REQ-033 SHALL cover: adjust=1, select=1 -> the seconds digits are visible for 8 clocks, then blank for 8 clocks, repeating, while the minutes digits stay lit.
REQ-034 SHALL cover: adjust dropped during a blank phase -> the seconds digits are visible at the next slot and the blink counter reads 0.
REQ-035 SHALL cover: reset pulsed during index 2 -> outputs go dark next edge, then restart at an=1110.

Source files
------------

// File: rtl/scan_display_driver_pkg.sv
// Shared constants for the multiplexed 4-digit mm:ss display driver:
// segment codes, anode idle pattern, default dividers and the BCD split helper.
package scan_display_driver_pkg;

    localparam int SCAN_DIV_DEFAULT  = 100000;
    localparam int BLINK_DIV_DEFAULT = 33333333;

    // Cathode codes {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Out-of-range inputs (60-63) are shown as 59 rather than as garbage digits
    function automatic bcd_t to_bcd(input logic [5:0] value);
        logic [5:0] clamped;
        bcd_t       result;
        clamped     = (value > 6'd59) ? 6'd59 : value;
        result.tens = 4'(clamped / 6'd10);
        result.ones = 4'(clamped % 6'd10);
        return result;
    endfunction

endpackage

// File: rtl/scan_display_driver_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment lookup; codes 10-15 go dark.
module seg7_decoder
    import scan_display_driver_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/scan_display_driver.sv
// Time-multiplexed mm:ss driver for a 4-digit common-anode display, with an
// optional blinking field for time adjustment. Outputs only move at slot updates.
module scan_display_driver
    import scan_display_driver_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
    parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       adjust,
    input  logic       select,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on;
    logic [1:0]         r_idx;
    logic [5:0]         r_snap_min;
    logic [5:0]         r_snap_sec;
    logic               r_running;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;

    logic               w_first;
    logic               w_wrap;
    logic               w_update;
    logic               w_capture;
    logic [1:0]         w_idx_next;
    logic [5:0]         w_min_src;
    logic [5:0]         w_sec_src;
    bcd_t               w_min_bcd;
    bcd_t               w_sec_bcd;
    logic [3:0]         w_digit;
    logic [6:0]         w_seg_code;
    logic [BLINK_W-1:0] w_blink_cnt_next;
    logic               w_blink_on_next;
    logic               w_blank;

    // The first edge out of reset behaves like a frame start without advancing the counter
    assign w_first   = ~r_running;
    assign w_wrap    = (r_scan_cnt == SCAN_LAST);
    assign w_update  = w_first | w_wrap;
    assign w_capture = w_first | (w_wrap & (r_idx == 2'd3));

    always_comb begin
        w_idx_next = r_idx;
        if (w_first) begin
            w_idx_next = 2'd0;
        end else if (w_wrap) begin
            w_idx_next = r_idx + 2'd1;
        end
    end

    // Digits for a new frame come straight from the inputs being captured this edge
    assign w_min_src = w_capture ? minutes : r_snap_min;
    assign w_sec_src = w_capture ? seconds : r_snap_sec;
    assign w_min_bcd = to_bcd(w_min_src);
    assign w_sec_bcd = to_bcd(w_sec_src);

    always_comb begin
        w_digit = w_sec_bcd.ones;
        case (w_idx_next)
            2'd0: w_digit = w_sec_bcd.ones;
            2'd1: w_digit = w_sec_bcd.tens;
            2'd2: w_digit = w_min_bcd.ones;
            2'd3: w_digit = w_min_bcd.tens;
            default: w_digit = w_sec_bcd.ones;
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .i_digit (w_digit),
        .o_seg   (w_seg_code)
    );

    always_comb begin
        w_blink_cnt_next = '0;
        w_blink_on_next  = 1'b1;
        if (adjust) begin
            w_blink_on_next = r_blink_on;
            if (r_blink_cnt == BLINK_LAST) begin
                w_blink_on_next = ~r_blink_on;
            end else begin
                w_blink_cnt_next = r_blink_cnt + 1'b1;
            end
        end
    end

    // Slots 0/1 carry seconds, 2/3 carry minutes; blink_on is forced high when not adjusting
    assign w_blank = ~w_blink_on_next & (select == ~w_idx_next[1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_idx       <= 2'd0;
            r_snap_min  <= 6'd0;
            r_snap_sec  <= 6'd0;
            r_running   <= 1'b0;
            r_an        <= AN_OFF;
            r_seg       <= SEG_BLANK;
        end else begin
            r_running   <= 1'b1;
            r_blink_cnt <= w_blink_cnt_next;
            r_blink_on  <= w_blink_on_next;
            r_idx       <= w_idx_next;
            if (w_first || w_wrap) begin
                r_scan_cnt <= '0;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            if (w_capture) begin
                r_snap_min <= minutes;
                r_snap_sec <= seconds;
            end
            if (w_update) begin
                r_an  <= ~(4'b0001 << w_idx_next);
                r_seg <= w_blank ? SEG_BLANK : w_seg_code;
            end
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_scan_display_driver.sv
// Directed bench for scan_display_driver with SCAN_DIV=4, BLINK_DIV=8.
module tb_scan_display_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adjust;
    logic       select;
    logic [6:0] seg;
    logic [3:0] an;

    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    int n_checks = 0;
    int n_pass   = 0;

    scan_display_driver #(
        .SCAN_DIV  (4),
        .BLINK_DIV (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .minutes (minutes),
        .seconds (seconds),
        .adjust  (adjust),
        .select  (select),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for the slot-update edge, then checks the first and last clock of the slot
    task automatic slot_check(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_an_first"}, 32'(an), 32'(e_an));
        check_eq({tag, "_seg_first"}, 32'(seg), 32'(e_seg));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_an_last"}, 32'(an), 32'(e_an));
        check_eq({tag, "_seg_last"}, 32'(seg), 32'(e_seg));
    endtask

    logic [3:0] bl_an  [8] = '{4'b1011, 4'b0111, 4'b1110, 4'b1101,
                               4'b1011, 4'b0111, 4'b1110, 4'b1101};
    logic [6:0] bl_seg [8] = '{S9, S5, SB, SB, S9, S5, SB, S3};

    initial begin
        logic exp_on;
        reset   = 1'b1;
        minutes = 6'd12;
        seconds = 6'd34;
        adjust  = 1'b0;
        select  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_an", 32'(an), 32'(4'b1111));
        check_eq("reset_seg", 32'(seg), 32'(SB));
        reset = 1'b0;

        slot_check("f1_s0", 4'b1110, S4);
        slot_check("f1_s1", 4'b1101, S3);
        slot_check("f1_s2", 4'b1011, S2);
        slot_check("f1_s3", 4'b0111, S1);

        slot_check("f2_s0", 4'b1110, S4);
        slot_check("f2_s1", 4'b1101, S3);
        seconds = 6'd35;
        slot_check("f2_s2", 4'b1011, S2);
        slot_check("f2_s3", 4'b0111, S1);

        slot_check("f3_s0", 4'b1110, S5);
        slot_check("f3_s1", 4'b1101, S3);
        minutes = 6'd63;
        slot_check("f3_s2", 4'b1011, S2);
        slot_check("f3_s3", 4'b0111, S1);

        slot_check("f4_s0", 4'b1110, S5);
        slot_check("f4_s1", 4'b1101, S3);
        slot_check("f4_s2", 4'b1011, S9);
        slot_check("f4_s3", 4'b0111, S5);

        slot_check("f5_s0", 4'b1110, S5);
        slot_check("f5_s1", 4'b1101, S3);

        // Blink seconds starting at the minutes-ones slot edge; drop adjust mid blank phase
        adjust = 1'b1;
        select = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("blink_an_k%0d", k), 32'(an), 32'(bl_an[k/4]));
            check_eq($sformatf("blink_seg_k%0d", k), 32'(seg), 32'(bl_seg[k/4]));
            exp_on = (k >= 27) ? 1'b1 : ((((k + 1) / 8) % 2) == 0);
            check_eq($sformatf("blink_on_k%0d", k), 32'(dut.r_blink_on), 32'(exp_on));
            if (k >= 27) begin
                check_eq($sformatf("blink_cnt_k%0d", k), 32'(dut.r_blink_cnt), 32'd0);
            end
            if (k == 26) begin
                adjust = 1'b0;
            end
        end

        // Reset pulse in the middle of the minutes-ones slot
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("midreset_an", 32'(an), 32'(4'b1111));
        check_eq("midreset_seg", 32'(seg), 32'(SB));
        reset = 1'b0;

        slot_check("r_s0", 4'b1110, S5);
        slot_check("r_s1", 4'b1101, S3);
        slot_check("r_s2", 4'b1011, S9);
        slot_check("r_s3", 4'b0111, S5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
